// File: rtl/cfi_pkg.sv
// Shared types for the CFI dispatch scheduler: log entries, exception report,
// fault causes and the scheduler FSM encoding.
package cfi_pkg;

  localparam int unsigned PC_W = 32;
  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    CFI_BRANCH = 2'd0,
    CFI_JUMP   = 2'd1,
    CFI_CALL   = 2'd2,
    CFI_RETURN = 2'd3
  } cfi_kind_t;

  typedef struct packed {
    cfi_kind_t       kind;
    logic [PC_W-1:0] pc;
  } cfi_log_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  localparam logic [XLEN-1:0] CFI_CAUSE_CHECK   = XLEN'(24);
  localparam logic [XLEN-1:0] CFI_CAUSE_TIMEOUT = XLEN'(25);

  typedef enum logic {
    SCHED_RUN   = 1'b0,
    SCHED_FAULT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/cfi_sched_slot.sv
// Per-engine tracker: busy flag, pc of the outstanding check and its watchdog.
// Reports completion, check fault and timeout for the current cycle.
module cfi_sched_slot
  import cfi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dispatch_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            resp_valid_i,
  input  logic            resp_fault_i,
  output logic            busy_o,
  output logic            free_o,
  output logic            fault_o,
  output logic            timeout_o,
  output logic [PC_W-1:0] pc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            r_busy;
  logic [PC_W-1:0] r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic            w_expire;
  logic            w_release;

  // The counter would reach TIMEOUT_CYCLES on the closing edge of this cycle,
  // i.e. this is the TIMEOUT_CYCLES-th busy cycle after the pop edge.
  assign w_expire  = r_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_release = r_busy && (resp_valid_i || w_expire);

  assign fault_o   = r_busy && resp_valid_i && resp_fault_i;
  assign timeout_o = w_expire && !resp_valid_i;
  assign free_o    = !r_busy || w_release;
  assign busy_o    = r_busy;
  assign pc_o      = r_pc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
      r_pc   <= '0;
      r_cnt  <= '0;
    end else if (dispatch_i) begin
      r_busy <= 1'b1;
      r_pc   <= pc_i;
      r_cnt  <= '0;
    end else if (w_release) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfi_sched.sv
// Dispatches queued CFI logs to capable idle engines in queue order, watches
// each outstanding check and reports the first failure or timeout as a fault.
module cfi_sched
  import cfi_pkg::*;
#(
  parameter int unsigned NR_ENGINES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  cfi_log_t                   log_i,
  input  logic                       queue_empty_i,
  output logic                       queue_pop_o,
  input  logic [NR_ENGINES-1:0][3:0] eng_kind_mask_i,
  output logic [NR_ENGINES-1:0]      eng_req_o,
  input  logic [NR_ENGINES-1:0]      eng_gnt_i,
  output cfi_log_t                   eng_log_o,
  input  logic [NR_ENGINES-1:0]      eng_resp_valid_i,
  input  logic [NR_ENGINES-1:0]      eng_resp_fault_i,
  input  logic                       drain_i,
  output logic                       drained_o,
  input  logic                       fault_clear_i,
  output exception_t                 cfi_fault_o
);

  localparam int unsigned IDX_W = (NR_ENGINES > 1) ? $clog2(NR_ENGINES) : 1;

  sched_state_e                      r_state, w_state_nxt;
  exception_t                        r_fault;
  logic                              r_hold_vld;
  logic [IDX_W-1:0]                  r_hold_idx;

  logic [NR_ENGINES-1:0]             w_busy, w_free, w_chk_fault, w_timeout;
  logic [NR_ENGINES-1:0]             w_capable, w_dispatch;
  logic [NR_ENGINES-1:0][PC_W-1:0]   w_pc;
  logic                              w_sel_vld, w_dispatch_ok;
  logic [IDX_W-1:0]                  w_sel_idx;
  logic                              w_new_fault;
  exception_t                        w_new_excp;
  logic                              w_run, w_capture, w_clear;

  for (genvar e = 0; e < NR_ENGINES; e++) begin : g_slot
    cfi_sched_slot #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .dispatch_i  (w_dispatch[e]),
      .pc_i        (log_i.pc),
      .resp_valid_i(eng_resp_valid_i[e]),
      .resp_fault_i(eng_resp_fault_i[e]),
      .busy_o      (w_busy[e]),
      .free_o      (w_free[e]),
      .fault_o     (w_chk_fault[e]),
      .timeout_o   (w_timeout[e]),
      .pc_o        (w_pc[e])
    );
    assign w_capable[e] = w_free[e] && eng_kind_mask_i[e][log_i.kind];
  end

  // An outstanding request stays on its engine while that engine can still
  // take the head; otherwise the lowest-index capable engine is chosen.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    if (r_hold_vld && w_capable[r_hold_idx]) begin
      w_sel_vld = 1'b1;
      w_sel_idx = r_hold_idx;
    end else begin
      for (int e = int'(NR_ENGINES) - 1; e >= 0; e--) begin
        if (w_capable[e]) begin
          w_sel_vld = 1'b1;
          w_sel_idx = IDX_W'(e);
        end
      end
    end
  end

  assign w_dispatch_ok = rst_ni && w_run && !drain_i && !queue_empty_i && w_sel_vld;
  assign eng_req_o     = w_dispatch_ok ? (NR_ENGINES'(1) << w_sel_idx) : '0;
  assign w_dispatch    = eng_req_o & eng_gnt_i;
  assign queue_pop_o   = |w_dispatch;
  assign eng_log_o     = log_i;
  assign drained_o     = drain_i && !(|w_busy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_vld <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_hold_vld <= (|eng_req_o) && !queue_pop_o;
      r_hold_idx <= w_sel_idx;
    end
  end

  // Lowest-index failing engine wins; the rest are freed without a report.
  always_comb begin
    w_new_fault = 1'b0;
    w_new_excp  = '0;
    for (int e = int'(NR_ENGINES) - 1; e >= 0; e--) begin
      if (w_chk_fault[e] || w_timeout[e]) begin
        w_new_fault      = 1'b1;
        w_new_excp.valid = 1'b1;
        w_new_excp.cause = w_chk_fault[e] ? CFI_CAUSE_CHECK : CFI_CAUSE_TIMEOUT;
        w_new_excp.tval  = XLEN'(w_pc[e]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SCHED_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SCHED_RUN:   if (w_new_fault) w_state_nxt = SCHED_FAULT;
      SCHED_FAULT: if (fault_clear_i && !w_new_fault) w_state_nxt = SCHED_RUN;
      default:     w_state_nxt = SCHED_RUN;
    endcase
  end

  // A fault arriving together with a clear replaces the acknowledged one.
  always_comb begin
    w_run     = (r_state == SCHED_RUN);
    w_capture = w_new_fault && (w_run || fault_clear_i);
    w_clear   = !w_run && fault_clear_i && !w_new_fault;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault <= '0;
    end else if (w_capture) begin
      r_fault <= w_new_excp;
    end else if (w_clear) begin
      r_fault <= '0;
    end
  end

  assign cfi_fault_o = r_fault;

endmodule

// File: tb/tb_cfi_sched.sv
// Self-checking bench for cfi_sched: directed scenarios followed by random
// traffic, all checked every cycle against a queue/countdown reference model.
module tb_cfi_sched;
  import cfi_pkg::*;

  localparam int NE = 2;
  localparam int TO = 4;

  logic                clk = 1'b0;
  logic                rst_ni;
  cfi_log_t            log_i;
  logic                queue_empty_i;
  logic                queue_pop_o;
  logic [NE-1:0][3:0]  eng_kind_mask_i;
  logic [NE-1:0]       eng_req_o;
  logic [NE-1:0]       eng_gnt_i;
  cfi_log_t            eng_log_o;
  logic [NE-1:0]       eng_resp_valid_i;
  logic [NE-1:0]       eng_resp_fault_i;
  logic                drain_i;
  logic                drained_o;
  logic                fault_clear_i;
  exception_t          cfi_fault_o;

  cfi_sched #(
    .NR_ENGINES    (NE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .log_i           (log_i),
    .queue_empty_i   (queue_empty_i),
    .queue_pop_o     (queue_pop_o),
    .eng_kind_mask_i (eng_kind_mask_i),
    .eng_req_o       (eng_req_o),
    .eng_gnt_i       (eng_gnt_i),
    .eng_log_o       (eng_log_o),
    .eng_resp_valid_i(eng_resp_valid_i),
    .eng_resp_fault_i(eng_resp_fault_i),
    .drain_i         (drain_i),
    .drained_o       (drained_o),
    .fault_clear_i   (fault_clear_i),
    .cfi_fault_o     (cfi_fault_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log queue in front of the scheduler; pend holds entries that join at the next cycle.
  cfi_log_t q[$];
  cfi_log_t pend[$];

  function automatic void push(input cfi_kind_t k, input logic [31:0] pc);
    cfi_log_t l;
    l.kind = k;
    l.pc   = pc;
    pend.push_back(l);
  endfunction

  task automatic cycle(input logic [NE-1:0] gnt, input logic [NE-1:0] rv,
                       input logic [NE-1:0] rf, input logic drn, input logic clr);
    @(posedge clk);
    #1;
    while (pend.size() > 0) q.push_back(pend.pop_front());
    eng_gnt_i        = gnt;
    eng_resp_valid_i = rv;
    eng_resp_fault_i = rf;
    drain_i          = drn;
    fault_clear_i    = clr;
    if (q.size() > 0) begin
      log_i         = q[0];
      queue_empty_i = 1'b0;
    end else begin
      log_i         = '0;
      queue_empty_i = 1'b1;
    end
  endtask

  // Reference model: each engine holds a pc and the number of watchdog cycles
  // it has left; a pending request remembers its target engine.
  bit          m_busy [NE];
  logic [31:0] m_pc   [NE];
  int          m_left [NE];
  bit          m_in_fault;
  exception_t  m_fault;
  int          m_hold;

  function automatic void model_reset();
    for (int e = 0; e < NE; e++) begin
      m_busy[e] = 1'b0;
      m_pc[e]   = '0;
      m_left[e] = 0;
    end
    m_in_fault = 1'b0;
    m_fault    = '0;
    m_hold     = -1;
  endfunction

  initial begin
    logic [NE-1:0] free, cap, exp_req;
    int            sel;
    bit            exp_pop, found;
    exception_t    nf;
    cfi_kind_t     hk;
    model_reset();
    forever begin
      @(negedge clk);
      check("fault", 192'(cfi_fault_o), 192'(m_fault));
      if (!rst_ni) begin
        model_reset();
        check("rst_req", 192'(eng_req_o), 192'(0));
        check("rst_pop", 192'(queue_pop_o), 192'(0));
        check("rst_drained", 192'(drained_o), 192'(drain_i));
      end else begin
        hk  = (q.size() > 0) ? q[0].kind : CFI_BRANCH;
        sel = -1;
        for (int e = 0; e < NE; e++) begin
          free[e] = !m_busy[e] || eng_resp_valid_i[e] || (m_left[e] == 1);
          cap[e]  = free[e] && eng_kind_mask_i[e][hk];
        end
        if (m_hold >= 0 && cap[m_hold]) sel = m_hold;
        else for (int e = 0; e < NE; e++) if (cap[e] && sel < 0) sel = e;
        exp_req = '0;
        if (!m_in_fault && !drain_i && q.size() > 0 && sel >= 0) exp_req[sel] = 1'b1;
        exp_pop = |(exp_req & eng_gnt_i);

        check("req", 192'(eng_req_o), 192'(exp_req));
        check("pop", 192'(queue_pop_o), 192'(exp_pop));
        begin
          bit any_busy;
          any_busy = 1'b0;
          for (int e = 0; e < NE; e++) any_busy |= m_busy[e];
          check("drained", 192'(drained_o), 192'(drain_i && !any_busy));
        end
        if (q.size() > 0) check("log", 192'(eng_log_o), 192'(q[0]));

        found = 1'b0;
        nf    = '0;
        for (int e = 0; e < NE; e++) begin
          if (!found && m_busy[e]) begin
            if (eng_resp_valid_i[e] && eng_resp_fault_i[e]) begin
              found = 1'b1; nf.valid = 1'b1; nf.cause = CFI_CAUSE_CHECK; nf.tval = 64'(m_pc[e]);
            end else if (!eng_resp_valid_i[e] && m_left[e] == 1) begin
              found = 1'b1; nf.valid = 1'b1; nf.cause = CFI_CAUSE_TIMEOUT; nf.tval = 64'(m_pc[e]);
            end
          end
        end
        if (found && (!m_in_fault || fault_clear_i)) begin
          m_fault    = nf;
          m_in_fault = 1'b1;
        end else if (m_in_fault && fault_clear_i) begin
          m_fault    = '0;
          m_in_fault = 1'b0;
        end

        for (int e = 0; e < NE; e++) begin
          if (exp_pop && sel == e) begin
            m_busy[e] = 1'b1;
            m_pc[e]   = q[0].pc;
            m_left[e] = TO;
          end else if (m_busy[e] && (eng_resp_valid_i[e] || m_left[e] == 1)) begin
            m_busy[e] = 1'b0;
          end else if (m_busy[e]) begin
            m_left[e]--;
          end
        end
        m_hold = (exp_req != '0 && !exp_pop) ? sel : -1;
        if (exp_pop) void'(q.pop_front());
      end
    end
  end

  logic rnd_drain = 1'b0;

  task automatic rand_cycle();
    logic [NE-1:0] g, rv, rf;
    if ($urandom_range(63) == 0) eng_kind_mask_i[$urandom_range(NE-1)] = 4'($urandom);
    if ($urandom_range(31) == 0) rnd_drain = !rnd_drain;
    if (q.size() + pend.size() < 6 && $urandom_range(1) == 1)
      push(cfi_kind_t'($urandom_range(3)), $urandom);
    g = NE'($urandom);
    for (int e = 0; e < NE; e++) begin
      rv[e] = ($urandom_range(3) == 0);
      rf[e] = ($urandom_range(9) < 3);
    end
    cycle(g, rv, rf, rnd_drain, ($urandom_range(3) == 0));
  endtask

  initial begin
    exception_t ef;
    rst_ni           = 1'b0;
    eng_kind_mask_i  = {4'hF, 4'hF};
    log_i            = '0;
    queue_empty_i    = 1'b1;
    eng_gnt_i        = '0;
    eng_resp_valid_i = '0;
    eng_resp_fault_i = '0;
    drain_i          = 1'b1;
    fault_clear_i    = 1'b0;
    #2;
    check("reset_drained", 192'(drained_o), 192'(1));
    check("reset_fault", 192'(cfi_fault_o), 192'(0));
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0);
    #1 rst_ni = 1'b1;

    // Single CALL, same-cycle grant, clean response three cycles later.
    push(CFI_CALL, 32'h0000_1000);
    cycle(2'b01, '0, '0, 1'b0, 1'b0);
    #1 check("A_req", 192'(eng_req_o), 192'(2'b01));
    check("A_pop", 192'(queue_pop_o), 192'(1));
    cycle('0, '0, '0, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0);
    cycle('0, 2'b01, '0, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);
    #1 check("A_nofault", 192'(cfi_fault_o.valid), 192'(0));
    check("A_free", 192'(drained_o), 192'(1));

    // Two RETURNs only engine 1 can take; the second goes out in the response cycle.
    eng_kind_mask_i[0] = 4'b0111;
    eng_kind_mask_i[1] = 4'b1000;
    push(CFI_RETURN, 32'h0000_4000);
    push(CFI_RETURN, 32'h8000_0100);
    cycle(2'b10, '0, '0, 1'b0, 1'b0);
    #1 check("B_req1", 192'(eng_req_o), 192'(2'b10));
    check("B_pop1", 192'(queue_pop_o), 192'(1));
    cycle(2'b10, '0, '0, 1'b0, 1'b0);
    #1 check("B_wait", 192'(eng_req_o), 192'(0));
    cycle(2'b10, 2'b10, '0, 1'b0, 1'b0);
    #1 check("B_req2", 192'(eng_req_o), 192'(2'b10));
    check("B_pop2", 192'(queue_pop_o), 192'(1));

    // Check fault on engine 1; dispatch stalls until the clear.
    cycle(2'b10, '0, '0, 1'b0, 1'b0);
    cycle(2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
    push(CFI_RETURN, 32'h0000_5000);
    cycle(2'b10, '0, '0, 1'b0, 1'b0);
    ef       = '0;
    ef.valid = 1'b1;
    ef.cause = 64'd24;
    ef.tval  = 64'h0000_0000_8000_0100;
    #1 check("C_fault", 192'(cfi_fault_o), 192'(ef));
    check("C_hold1", 192'(queue_pop_o), 192'(0));
    cycle(2'b10, '0, '0, 1'b0, 1'b1);
    #1 check("C_hold2", 192'(queue_pop_o), 192'(0));
    cycle(2'b10, '0, '0, 1'b0, 1'b0);
    #1 check("C_cleared", 192'(cfi_fault_o.valid), 192'(0));
    check("C_resume", 192'(queue_pop_o), 192'(1));
    cycle('0, 2'b10, '0, 1'b0, 1'b0);

    // Timeout with no response, then a response landing in the expiry cycle.
    eng_kind_mask_i = {4'hF, 4'hF};
    push(CFI_BRANCH, 32'h0000_2000);
    cycle(2'b01, '0, '0, 1'b0, 1'b0);
    #1 check("D_pop", 192'(queue_pop_o), 192'(1));
    repeat (TO - 1) cycle('0, '0, '0, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0);
    #1 check("D_before", 192'(cfi_fault_o.valid), 192'(0));
    cycle('0, '0, '0, 1'b0, 1'b1);
    ef.cause = 64'd25;
    ef.tval  = 64'h2000;
    #1 check("D_timeout", 192'(cfi_fault_o), 192'(ef));
    cycle('0, '0, '0, 1'b0, 1'b0);
    #1 check("D_cleared", 192'(cfi_fault_o.valid), 192'(0));
    push(CFI_JUMP, 32'h0000_3000);
    cycle(2'b01, '0, '0, 1'b0, 1'b0);
    repeat (TO - 1) cycle('0, '0, '0, 1'b0, 1'b0);
    cycle('0, 2'b01, '0, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0);
    #1 check("D_resp_wins", 192'(cfi_fault_o.valid), 192'(0));

    // Both engines fail in the same cycle: engine 0 reported, both freed.
    push(CFI_BRANCH, 32'h0000_A000);
    push(CFI_BRANCH, 32'h0000_B000);
    cycle(2'b11, '0, '0, 1'b0, 1'b0);
    #1 check("E_req0", 192'(eng_req_o), 192'(2'b01));
    cycle(2'b11, '0, '0, 1'b0, 1'b0);
    #1 check("E_req1", 192'(eng_req_o), 192'(2'b10));
    cycle('0, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b1);
    ef.cause = 64'd24;
    ef.tval  = 64'hA000;
    #1 check("E_fault", 192'(cfi_fault_o), 192'(ef));
    check("E_freed", 192'(drained_o), 192'(1));

    // Drain with three queued logs and one busy engine.
    push(CFI_CALL, 32'h0000_C000);
    cycle(2'b01, '0, '0, 1'b0, 1'b0);
    #1 check("F_pop", 192'(queue_pop_o), 192'(1));
    push(CFI_CALL, 32'h0000_C100);
    push(CFI_JUMP, 32'h0000_C200);
    push(CFI_BRANCH, 32'h0000_C300);
    cycle(2'b11, '0, '0, 1'b1, 1'b0);
    #1 check("F_nopop1", 192'(queue_pop_o), 192'(0));
    check("F_busy", 192'(drained_o), 192'(0));
    cycle(2'b11, '0, '0, 1'b1, 1'b0);
    cycle(2'b11, 2'b01, '0, 1'b1, 1'b0);
    #1 check("F_resp_cycle", 192'(drained_o), 192'(0));
    cycle(2'b11, '0, '0, 1'b1, 1'b0);
    #1 check("F_drained", 192'(drained_o), 192'(1));
    check("F_nopop2", 192'(queue_pop_o), 192'(0));
    cycle(2'b01, '0, '0, 1'b0, 1'b0);
    #1 check("F_resume", 192'(queue_pop_o), 192'(1));
    cycle('0, '0, '0, 1'b0, 1'b0);
    #1 check("F_req_held", 192'(eng_req_o), 192'(2'b10));

    // Reset mid-check drops every output at once.
    #1 rst_ni = 1'b0;
    #1 check("R_req", 192'(eng_req_o), 192'(0));
    check("R_pop", 192'(queue_pop_o), 192'(0));
    check("R_fault", 192'(cfi_fault_o), 192'(0));
    check("R_drained0", 192'(drained_o), 192'(0));
    cycle('0, '0, '0, 1'b1, 1'b0);
    #1 check("R_drained1", 192'(drained_o), 192'(1));
    #1 rst_ni = 1'b1;

    repeat (1500) rand_cycle();
    repeat (4) cycle('0, '0, '0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
